// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package riscv_fetch_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

    // Value every FIFO slot holds out of reset, so an empty head reads as a NOP at PC 0.
    function automatic fetch_entry_t reset_entry();
        fetch_entry_t e;
        e.pc   = '0;
        e.word = NOP_INSTR;
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t; head is read straight from the storage registers.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    always_comb begin
        empty   = (r_count == '0);
        full    = (r_count == CNT_W'(DEPTH));
        w_rd_en = pop & ~empty;
        // A push into a full FIFO is only legal when the head leaves in the same cycle.
        w_wr_en = push & (~full | w_rd_en);
        dout    = r_mem[r_rd_ptr];
        count   = r_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= reset_entry();
            end
        end else if (w_wr_en && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr_en && w_rd_en) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator: owns the PC, reads the zero-latency ROM and buffers {pc, word} for decode.
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'd0,
    parameter int unsigned       PC_STEP  = 16,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_word,
    input  logic                     halt,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    logic [ADDR_W-1:0] r_pc;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    fetch_entry_t      w_din;
    fetch_entry_t      w_dout;

    always_comb begin
        imem_addr   = r_pc;
        w_din.pc    = r_pc;
        w_din.word  = imem_word;
        instr_valid = ~w_empty;
        w_pop       = ~w_empty & instr_ready;
        // A redirect cycle never fetches: the word at the old PC is already stale.
        w_push      = ~halt & ~redirect_valid & (~w_full | w_pop);
        instr       = w_dout.word;
        instr_pc    = w_dout.pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + ADDR_W'(PC_STEP);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   (w_din),
        .dout  (w_dout),
        .count (fifo_count),
        .empty (w_empty),
        .full  (w_full)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a queue-based reference model and a ROM stand-in.
module tb_instr_fetch_unit;
    import riscv_fetch_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int          STEP  = 16;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] word;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  imem_addr;
    logic [31:0] imem_word;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic [1:0]  fifo_count;

    ent_t m_fifo[$];
    ent_t exp_q[$];
    int   m_pc = 0;
    bit   m_live = 1'b0;
    bit   m_was_rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        case (a)
            8'd16:   return 32'h00868693;
            8'd32:   return 32'h00070733;
            8'd96:   return 32'h00050593;
            8'd240:  return 32'h00472303;
            default: return {a, a ^ 8'h5a, ~a, 8'h13};
        endcase
    endfunction

    assign imem_word = rom_word(imem_addr);

    instr_fetch_unit #(
        .RESET_PC (8'd0),
        .PC_STEP  (STEP),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_word      (imem_word),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fifo_count     (fifo_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check visible state against the model, then advance the model.
    task automatic cycle(input bit r, input bit h, input bit rv, input logic [7:0] rp,
                         input bit rdy);
        bit   popped;
        ent_t e;
        @(negedge clk);
        rst = r; halt = h; redirect_valid = rv; redirect_pc = rp; instr_ready = rdy;
        #1;
        if (m_live) begin
            check("imem_addr", imem_addr, m_pc);
            check("fifo_count", fifo_count, m_fifo.size());
            check("instr_valid", instr_valid, m_fifo.size() > 0);
            if (m_was_rst) begin
                check("reset_instr", instr, NOP_INSTR);
                check("reset_instr_pc", instr_pc, 0);
            end
        end
        popped = m_live && m_fifo.size() > 0 && rdy;
        if (popped) begin
            exp_q.push_back(m_fifo[0]);
            void'(m_fifo.pop_front());
        end
        if (r) begin
            m_fifo.delete();
            m_pc      = 0;
            m_live    = 1'b1;
            m_was_rst = 1'b1;
        end else begin
            m_was_rst = 1'b0;
            if (rv) begin
                m_fifo.delete();
                m_pc = rp;
            end else if (!h && m_fifo.size() < DEPTH) begin
                e.pc   = 8'(m_pc);
                e.word = rom_word(8'(m_pc));
                m_fifo.push_back(e);
                m_pc = (m_pc + STEP) % 256;
            end
        end
    endtask

    // Monitor: every handshake the DUT presents must match the next predicted delivery.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pop: got pc %h, expected no delivery", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", instr_pc, e.pc);
                    check("pop_word", instr, e.word);
                end
            end
        end
    end

    initial begin
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Free run from reset
        cycle(0, 0, 0, 0, 1);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", instr_valid, 0);
        cycle(0, 0, 0, 0, 1);
        check("run_pc0", instr_pc, 0);
        cycle(0, 0, 0, 0, 1);
        check("run_pc16", instr_pc, 16);
        check("run_w16", instr, 32'h00868693);
        cycle(0, 0, 0, 0, 1);
        check("run_pc32", instr_pc, 32);
        check("run_w32", instr, 32'h00070733);

        // Backpressure
        cycle(1, 0, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0, 0);
        check("bp_count", fifo_count, 2);
        check("bp_addr", imem_addr, 32);
        repeat (6) cycle(0, 0, 0, 0, 1);

        // Redirect with full FIFO
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 8'd96, 0);
        cycle(0, 0, 0, 0, 0);
        check("redir_valid", instr_valid, 0);
        check("redir_count", fifo_count, 0);
        cycle(0, 0, 0, 0, 1);
        check("redir_pc", instr_pc, 96);
        check("redir_word", instr, 32'h00050593);

        // Wrap
        cycle(0, 0, 1, 8'd240, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("wrap_pc240", instr_pc, 240);
        check("wrap_w240", instr, 32'h00472303);
        cycle(0, 0, 0, 0, 1);
        check("wrap_pc0", instr_pc, 0);
        cycle(0, 0, 0, 0, 1);
        check("wrap_pc16", instr_pc, 16);

        // Halt drains buffered entries
        repeat (3) cycle(0, 0, 0, 0, 0);
        check("halt_full", fifo_count, 2);
        repeat (4) cycle(0, 1, 0, 0, 1);
        check("halt_valid", instr_valid, 0);
        repeat (4) cycle(0, 0, 0, 0, 1);

        // Reset beats redirect
        cycle(1, 0, 1, 8'd128, 1);
        cycle(0, 0, 0, 0, 0);
        check("rstredir_addr", imem_addr, 0);
        check("rstredir_valid", instr_valid, 0);
        check("rstredir_count", fifo_count, 0);

        repeat (3000) begin
            cycle($urandom_range(99) == 0, $urandom_range(5) == 0, $urandom_range(9) == 0,
                  8'($urandom_range(255)), $urandom_range(2) != 0);
        end

        repeat (4) cycle(0, 0, 0, 0, 1);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
